// File: rtl/mips_pkg.sv
// mips_pkg: MIPS opcode/funct encodings, loader request ops and loader FSM states.
package mips_pkg;
  localparam logic [5:0] R_FORMAT = 6'b000000;
  localparam logic [5:0] LW       = 6'b100011;
  localparam logic [5:0] SW       = 6'b101011;
  localparam logic [5:0] BEQ      = 6'b000100;
  localparam logic [5:0] ADDI     = 6'b001000;
  localparam logic [5:0] J        = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_ADDI = 4'd8,
    OP_J    = 4'd9
  } instr_op_t;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} ld_state_t;
endpackage

// File: rtl/instr_encode.sv
// instr_encode: packs a symbolic request into a 32-bit MIPS word; flags ops 10-15.
module instr_encode
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);
  always_comb begin
    word = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  word = {R_FORMAT, rs, rt, rd, 5'd0, F_ADD};
      OP_SUB:  word = {R_FORMAT, rs, rt, rd, 5'd0, F_SUB};
      OP_AND:  word = {R_FORMAT, rs, rt, rd, 5'd0, F_AND};
      OP_OR:   word = {R_FORMAT, rs, rt, rd, 5'd0, F_OR};
      OP_SLT:  word = {R_FORMAT, rs, rt, rd, 5'd0, F_SLT};
      OP_LW:   word = {LW, rs, rt, imm};
      OP_SW:   word = {SW, rs, rt, imm};
      OP_BEQ:  word = {BEQ, rs, rt, imm};
      OP_ADDI: word = {ADDI, rs, rt, imm};
      OP_J:    word = {J, target};
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: accepts encoded-instruction requests and writes them to consecutive imem words.
module instr_loader
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [4:0]            req_rs,
  input  logic [4:0]            req_rt,
  input  logic [4:0]            req_rd,
  input  logic [15:0]           req_imm,
  input  logic [25:0]           req_target,
  input  logic                  req_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] TOP  = '1;
  ld_state_t state, state_n;
  logic [31:0] word;
  logic illegal, last_q, hs, at_top;
  instr_encode u_enc (
    .op(req_op),
    .rs(req_rs),
    .rt(req_rt),
    .rd(req_rd),
    .imm(req_imm),
    .target(req_target),
    .word(word),
    .illegal(illegal)
  );
  assign hs = req_valid & req_ready;
  assign at_top = imem_addr == TOP;
  // Outputs are gated by reset so an aborted WRITE never strobes imem.
  assign req_ready = state == LOAD && !reset;
  assign imem_we = state == WRITE && !reset;
  assign busy = state == LOAD || state == WRITE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = !hs ? LOAD : !illegal ? WRITE : req_last ? DONE : LOAD;
      WRITE:   state_n = (last_q || at_top) ? DONE : LOAD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_addr <= BASE;
      imem_wdata <= '0;
      count <= '0;
      err <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        imem_addr <= BASE;
        count <= '0;
        err <= 1'b0;
      end
      if (state == LOAD && hs) begin
        if (illegal) err <= 1'b1;
        else begin
          imem_wdata <= word;
          last_q <= req_last;
        end
      end
      if (state == WRITE) begin
        imem_addr <= imem_addr + 1'b1;
        count <= count + 1'b1;
        if (!last_q && at_top) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader at ADDR_WIDTH 6 and 2.
module tb_instr_loader;
  logic clk = 0, reset = 1, start = 0, req_valid = 0, req_last = 0;
  logic [3:0] req_op = 0;
  logic [4:0] req_rs = 0, req_rt = 0, req_rd = 0;
  logic [15:0] req_imm = 0;
  logic [25:0] req_target = 0;
  logic ready1, we1, busy1, done1, err1, ready2, we2, busy2, done2, err2;
  logic [5:0] addr1;
  logic [6:0] count1;
  logic [1:0] addr2;
  logic [2:0] count2;
  logic [31:0] wdata1, wdata2;
  logic sel = 0;
  logic m_we, m_ready, m_busy, m_done, m_err;
  logic [6:0] m_addr, m_count;
  logic [31:0] m_data;
  int n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0;
  typedef struct {
    logic [6:0] addr;
    logic [31:0] data;
    int cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_loader #(.ADDR_WIDTH(6), .BASE_ADDR(0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_ready(ready1),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_target(req_target), .req_last(req_last), .imem_we(we1), .imem_addr(addr1),
    .imem_wdata(wdata1), .busy(busy1), .done(done1), .err(err1), .count(count1)
  );
  instr_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_ready(ready2),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_target(req_target), .req_last(req_last), .imem_we(we2), .imem_addr(addr2),
    .imem_wdata(wdata2), .busy(busy2), .done(done2), .err(err2), .count(count2)
  );

  assign m_we = sel ? we2 : we1;
  assign m_ready = sel ? ready2 : ready1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;
  assign m_err = sel ? err2 : err1;
  assign m_addr = sel ? {5'd0, addr2} : {1'b0, addr1};
  assign m_count = sel ? {4'd0, count2} : count1;
  assign m_data = sel ? wdata2 : wdata1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_we) begin
      if (sb.size() == 0) check("unexpected_we", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", m_addr, e.addr);
        check("wr_data", m_data, e.data);
        check("wr_latency", cyc, e.cyc);
        check("ready_in_write", m_ready, 0);
        check("busy_in_write", m_busy, 1);
      end
    end
    if (m_done) done_cnt++;
  end

  task automatic do_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last, input logic push,
                      input logic [6:0] a, input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_target = tgt; req_last = last; req_valid = 1;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) begin
      check("hs_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 0;
    req_last = 0;
    // the WRITE cycle is observed at the negedge right after the handshake edge
    if (push) sb.push_back('{a, w, cyc});
  endtask

  task automatic wait_end(input string tag, input int d0);
    int n = 0;
    while ((m_busy || m_done) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_end_timeout"}, n < 30, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, we1, 0);
    check({tag, "_ready"}, ready1, 0);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_done"}, done1, 0);
    check({tag, "_err"}, err1, 0);
    check({tag, "_addr"}, addr1, 0);
    check({tag, "_wdata"}, wdata1, 0);
    check({tag, "_count"}, count1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, seen;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 0;
    @(negedge clk);
    check("idle_ready", ready1, 0);

    // single ADD, last
    d0 = done_cnt;
    do_start();
    check("load_busy", busy1, 1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, 1, 7'd0, 32'h00221820);
    wait_end("s1", d0);
    check("s1_count", count1, 1);

    // LW then SW
    d0 = done_cnt;
    do_start();
    send(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 0, 1, 7'd0, 32'h8FA80004);
    send(4'd6, 5'd0, 5'd2, 5'd7, 16'h0008, 26'h0, 1, 1, 7'd1, 32'hAC020008);
    wait_end("s2", d0);
    check("s2_count", count1, 2);

    // BEQ, ADDI, J
    d0 = done_cnt;
    do_start();
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 0, 1, 7'd0, 32'h1022FFFF);
    send(4'd8, 5'd0, 5'd1, 5'd0, 16'h0005, 26'h0, 0, 1, 7'd1, 32'h20010005);
    send(4'd9, 5'd3, 5'd4, 5'd5, 16'h1234, 26'h0100000, 1, 1, 7'd2, 32'h08100000);
    wait_end("s3", d0);
    check("s3_count", count1, 3);
    check("s3_err", err1, 0);

    // illegal op mid-session
    d0 = done_cnt;
    do_start();
    check("s4_err_cleared", err1, 0);
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 0, 1, 7'd0, 32'h00853022);
    send(4'd12, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 0, 0, 7'd0, 32'h0);
    @(negedge clk);
    check("ill_err", err1, 1);
    check("ill_addr", addr1, 1);
    check("ill_count", count1, 1);
    check("ill_stay_load", ready1, 1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, 1, 7'd1, 32'h00221820);
    wait_end("s4", d0);
    check("s4_count", count1, 2);
    check("s4_err_sticky", err1, 1);

    // reset during WRITE aborts the session
    do_start();
    check("s5_err_cleared", err1, 0);
    send(4'd4, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 0, 0, 7'd0, 32'h0);
    reset = 1;
    @(negedge clk);
    check("rstw_no_we", we1, 0);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check_reset_vals("rstw");
    repeat (3) @(negedge clk);
    check("rstw_needs_start", ready1, 0);

    // overflow on the ADDR_WIDTH=2 instance
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    sel = 1;
    d0 = done_cnt;
    do_start();
    send(4'd0, 5'd1, 5'd2, 5'd1, 16'h0, 26'h0, 0, 1, 7'd0, 32'h00220820);
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 0, 1, 7'd1, 32'h00853022);
    send(4'd2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 0, 1, 7'd2, 32'h00E84824);
    send(4'd3, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0, 0, 1, 7'd3, 32'h014B6025);
    req_op = 4'd4; req_valid = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_ready) seen++;
    end
    req_valid = 0;
    check("ovf_not_accepted", seen, 0);
    check("ovf_err", m_err, 1);
    check("ovf_count", m_count, 4);
    check("ovf_done_once", done_cnt - d0, 1);
    check("ovf_sb_empty", sb.size(), 0);
    check("ovf_idle", m_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Sequential instruction encoder/loader for the single-cycle MIPS.
- It accepts symbolic instruction requests (operation plus fields), encodes each into a 32-bit MIPS word, and writes the words into instruction memory at consecutive word addresses.
- It is the inverse of the opcode decoder: it produces the opcode/funct encodings that the main and ALU control units consume. Testbenches and boot logic use it to fill imem.

Parameters:
- ADDR_WIDTH, 6, width of the imem word address. Capacity is 2**ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a load session; honoured only in IDLE.
- req_valid  in  1  request present.
- req_ready  out  1  loader can accept a request this cycle.
- req_op  in  4  operation (enum instr_op_t): ADD=0, SUB=1, AND=2, OR=3, SLT=4, LW=5, SW=6, BEQ=7, ADDI=8, J=9; 10-15 are illegal.
- req_rs  in  5  source register rs.
- req_rt  in  5  register rt.
- req_rd  in  5  destination register rd (R-type only).
- req_imm  in  16  immediate/offset (I-type).
- req_target  in  26  jump target field (J).
- req_last  in  1  marks the final request of the session.
- imem_we  out  1  imem write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  imem word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high in LOAD and WRITE.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky: illegal op or overflow; cleared by start or reset.
- count  out  ADDR_WIDTH+1  words written this session.

Behaviour:
- Reset (synchronous, active-high):
  - State becomes IDLE.
  - imem_we, done, err and busy are 0; req_ready is 0.
  - imem_addr becomes BASE_ADDR; imem_wdata and count become 0.
  - Reset asserted mid-session aborts the session. No write occurs in the reset cycle.
- FSM states are IDLE, LOAD, WRITE and DONE.
- IDLE:
  - start=1 moves to LOAD, sets imem_addr to BASE_ADDR, clears count and clears err.
  - start is ignored in every state other than IDLE.
- LOAD:
  - req_ready=1.
  - A handshake (req_valid & req_ready) latches the encoded word into imem_wdata and moves to WRITE.
  - req_last is latched at the same time.
- WRITE:
  - imem_we=1 for exactly this one cycle, with imem_addr and imem_wdata stable.
  - req_ready=0, so throughput is one word per 2 cycles.
  - Latency is handshake at cycle N, imem_we at N+1.
  - At the end of the cycle, count increments and imem_addr increments (wrapping mod 2**ADDR_WIDTH).
  - Next state is DONE if the latched last flag is set, else DONE with err=1 if this write was at address 2**ADDR_WIDTH-1, else LOAD.
- DONE: done=1 for one cycle, then IDLE.
- Illegal req_op (10-15) accepted in LOAD:
  - err is set.
  - No WRITE occurs, so imem_addr and count are unchanged.
  - The state stays in LOAD, unless req_last=1, in which case it moves to DONE.
- Encoding, per field layout:
  - R-type: {000000, rs, rt, rd, 00000, funct}. funct values are ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - ADDI: {001000, rs, rt, imm}.
  - J: {000010, target}.
- Fields not used by an op are ignored; for example, rd is ignored for I-type.

Decomposition:
- Package mips_pkg holds:
  - opcode constants: R_FORMAT, LW, SW, BEQ, ADDI, J;
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - the instr_op_t enum;
  - the loader state enum.
- One combinational sub-module, instr_encode:
  - inputs are op and the fields;
  - outputs are a 32-bit word and an illegal flag.
- instr_encode is instantiated once. The FSM, counters and handshake live in instr_loader.

Test Plan:
- start, then ADD rs=1 rt=2 rd=3 -> imem_we one cycle after the handshake; addr 0 = 0x00221820.
- LW rs=29 rt=8 imm=4, then SW rs=0 rt=2 imm=8 -> addr 0 = 0x8FA80004; addr 1 = 0xAC020008; req_ready low during each WRITE cycle.
- BEQ rs=1 rt=2 imm=0xFFFF, ADDI rs=0 rt=1 imm=5, J target=0x0100000 with req_last -> words 0x1022FFFF, 0x20010005, 0x08100000; done pulses once; count=3.
- req_op=12 mid-session -> err=1, no imem_we, address unchanged; the following valid ADD is written at the old address; err stays 1 until the next start.
- ADDR_WIDTH=2, 5 requests without req_last -> 4 writes at 0-3, then done with err=1, fifth request not accepted (req_ready=0).
- reset asserted in the WRITE cycle -> no imem_we that cycle; all outputs at reset values; start is required to resume.
